// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, picks the next PC from redirects/stall, and fills the IF/ID register.
// Latency: one cycle from imem_data at the edge to if_id_instr.
// Backpressure: stall holds the PC and IF/ID; exception/branch still redirect and insert a bubble.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] EXC_PC   = 32'h8000_0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        exception,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [15:0] if_id_imm,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    ifid_t       ifid;
    ifid_t       ifid_next;
    logic        load_valid;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 becomes 0.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        if (exception) begin
            pc_next = EXC_PC & ALIGN_MASK;
        end else if (branch_taken) begin
            pc_next = branch_target & ALIGN_MASK;
        end else if (stall) begin
            pc_next = pc;
        end else if (jump) begin
            pc_next = jump_target & ALIGN_MASK;
        end
    end

    // A jump only squashes when not stalled; exception/branch/flush squash regardless of stall.
    always_comb begin
        ifid_next  = ifid;
        load_valid = 1'b0;
        if (exception || branch_taken || flush) begin
            ifid_next = '0;
        end else if (stall) begin
            ifid_next = ifid;
        end else if (jump) begin
            ifid_next = '0;
        end else begin
            ifid_next.instr = imem_data;
            ifid_next.pc4   = pc_plus4;
            ifid_next.valid = 1'b1;
            load_valid      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            ifid        <= '0;
            fetch_count <= '0;
        end else begin
            pc   <= pc_next;
            ifid <= ifid_next;
            if (load_valid && (fetch_count != 32'hFFFF_FFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

    assign imem_addr   = pc;
    assign if_id_instr = ifid.instr;
    assign if_id_pc4   = ifid.pc4;
    assign if_id_valid = ifid.valid;
    assign if_id_imm   = ifid.instr[15:0];

endmodule
